// File: rtl/clk_divider.sv
`default_nettype none
// ============================================================================
//  Module   : clk_divider
//  Purpose  : Synchronous divide-by-N tick / clock-enable generator with a
//             near-50 % duty clk_out, a one-cycle tick per period and a
//             runtime-reloadable divisor that is applied only at period
//             boundaries (or immediately on clear).
//  Options  : CLK_DIV_PERIOD_CNT_EN adds a 16-bit completed-period counter
//             output 'periods'.
//  Revision : 1.0  initial release
// ============================================================================
module clk_divider #(
  parameter int          WIDTH       = 26,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             clk_out,
  output logic             tick
`ifdef CLK_DIV_PERIOD_CNT_EN
  ,
  output logic [15:0]      periods
`endif
);

  localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_DEFAULT  = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] n_q,    n_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] n_eff;      // divisor with 0 mapped to 1
  logic [WIDTH-1:0] n_last;     // last count value of a period
  logic [WIDTH-1:0] n_half;     // ceil(N/2): count at which clk_out falls
  logic             at_boundary;

  // Derived period limits from the active divisor
  always_comb begin
    n_eff       = (n_q == '0) ? C_ONE : n_q;
    n_last      = n_eff - C_ONE;
    // ceil(N/2) without the overflow risk of (N+1)>>1
    n_half      = (n_eff >> 1) + {{(WIDTH-1){1'b0}}, n_eff[0]};
    // >= keeps the counter self-recovering should it ever exceed the limit
    at_boundary = enable && (cnt_q >= n_last);
  end

  // Next-state: clear > boundary > count; divisor loads are captured always
  always_comb begin
    cnt_d     = cnt_q;
    n_d       = n_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;

    if (div_load) begin
      pend_d   = div_in;
      pend_v_d = 1'b1;
    end

    if (clear) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      pend_v_d  = 1'b0;
      // A same-cycle load takes precedence over an older pending value
      if (div_load) begin
        n_d = div_in;
      end else if (pend_v_q) begin
        n_d = pend_q;
      end
    end else if (at_boundary) begin
      cnt_d     = '0;
      tick_d    = 1'b1;
      clk_out_d = 1'b1;
      // The old pending value is applied; a same-cycle load stays pending
      if (pend_v_q) begin
        n_d = pend_q;
        if (!div_load) begin
          pend_v_d = 1'b0;
        end
      end
    end else if (enable) begin
      cnt_d = cnt_q + C_ONE;
      if (cnt_d == n_half) begin
        clk_out_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      n_q       <= C_DEFAULT;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign div_busy = pend_v_q;
  assign clk_out  = clk_out_q;
  assign tick     = tick_q;

`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [15:0] periods_q, periods_d;

  // Completed-period count; clear suppresses the boundary but never zeroes it
  always_comb begin
    periods_d = periods_q;
    if (!clear && at_boundary) begin
      periods_d = periods_q + 16'd1;
    end
  end

  // Period counter register, reset only by the async reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      periods_q <= 16'd0;
    end else begin
      periods_q <= periods_d;
    end
  end

  assign periods = periods_q;
`endif

endmodule
`default_nettype wire

// File: doc/clk_divider.md
# clk_divider

Parametrised synchronous clock divider / tick generator for the 50 MHz board clock, replacing fixed ripple divide-by-N chains in the timing path. It produces a near-50 % duty `clk_out`, a one-cycle `tick` strobe per period and a runtime-reloadable divisor. Its outputs drive the motor PWM, sensor sampling and display refresh logic. Both outputs are intended as clock enables, not as clocks.

## Interface
- `WIDTH`, 26: width of the divisor and the internal counter. 26 covers 50 MHz → 1 Hz.
- `DEFAULT_DIV`, 5: divisor loaded at reset. Must be < 2^WIDTH.
- `clk`  input  1  board clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset. Asserting it clears state immediately; release is synchronous to `clk`.
- `enable`  input  1  count enable; when low, the counter freezes.
- `clear`  input  1  synchronous restart of the current period.
- `div_in`  input  WIDTH  new divisor value.
- `div_load`  input  1  one-cycle strobe that captures `div_in`.
- `div_busy`  output  1  a captured divisor is pending and not yet applied.
- `clk_out`  output  1  divided square wave (registered).
- `tick`  output  1  one-cycle pulse at each period start (registered).
- `periods`  output  16  completed-period count. Present only with `CLK_DIV_PERIOD_CNT_EN`.

## Operation
- Registers: `cnt` (WIDTH), active divisor `N` (WIDTH), `pend` (WIDTH), `pend_v`, `clk_out`, `tick`.
- Effective divisor: `N` = 0 is treated as 1.
- Derived values: H = ceil(N/2) and L = floor(N/2).
- Reset values: `cnt` = 0, `N` = `DEFAULT_DIV`, `pend_v` = 0, `clk_out` = 0, `tick` = 0, `div_busy` = 0, `periods` = 0.
- Enabled cycle:
  - If `cnt` = N−1, then `cnt` ← 0, `tick` ← 1 and `clk_out` ← 1. This is the boundary edge.
  - Otherwise `cnt` ← `cnt`+1 and `tick` ← 0.
  - `clk_out` ← 0 on the edge where `cnt` becomes H. This gives H cycles high and L cycles low.
- N = 1: `tick` is high on every enabled cycle and `clk_out` stays 1.
- `enable` low: `cnt` and `clk_out` hold, and `tick` ← 0 on the next edge.
- `div_load`: `pend` ← `div_in` and `pend_v` ← 1. A load while `pend_v` = 1 overwrites `pend`; the last value wins.
- Pending apply: at the boundary edge, if `pend_v`, then `N` ← `pend` and `pend_v` ← 0. The new period uses the new N.
- Simultaneous `div_load` and boundary: the boundary applies the old `pend` (if valid), and the new value becomes pending.
- `clear`, evaluated regardless of `enable`: `cnt` ← 0, `tick` ← 0, `clk_out` ← 0.
  - Any pending divisor is applied immediately.
  - A `div_load` in the same cycle as `clear` is applied directly, and `pend_v` stays 0.
  - Counting resumes on the next enabled edge. The first boundary follows N enabled edges.
- Priority: `reset` > `clear` > boundary > count.
- `div_busy` = `pend_v`.

## Timing
- After `reset` is released, the first `tick` and rising `clk_out` occur on the N-th enabled rising edge.
- Thereafter `tick` occurs every N enabled edges and is exactly 1 cycle wide.
- `clk_out` rises in the same cycle `tick` is high. Both are registered with zero extra latency.
- Divisor change latency: takes effect at the first boundary after the load edge. `div_busy` is high from the edge after `div_load` until the boundary edge.
- Changing N never truncates the period in progress. The only exception is `clear`.
- Asserting `reset` mid-period forces all outputs to their reset values asynchronously. No glitch on `tick` is permitted after reset release.

## Configuration
- `CLK_DIV_PERIOD_CNT_EN` defined:
  - Adds the `periods` output, a 16-bit counter that increments on every boundary edge and wraps 0xFFFF → 0.
  - `periods` is cleared by `reset` only; `clear` does not affect it.
- `CLK_DIV_PERIOD_CNT_EN` not defined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- Reset release with `DEFAULT_DIV` = 5, `enable` = 1 → `tick` high at edges 5, 10, 15. `clk_out` is high for 3 cycles and low for 2.
- `div_load` with `div_in` = 4 at edge 7 → `div_busy` is 1 for edges 8–10. N = 4 from the edge-10 boundary, so the next ticks are at 14 and 18, with `clk_out` 2 cycles high and 2 low.
- `enable` held low for 3 cycles mid-period → tick spacing stretches from 5 to 8 edges. `tick` is never high while `enable` is low, and `clk_out` holds.
- `clear` at `cnt` = 3 with `div_in` = 2 pending → outputs are 0 on the next edge and N = 2. Ticks follow every 2 edges, and `div_busy` is 0.
- `div_in` = 0 and `div_in` = 1 each loaded → `tick` is high on every cycle and `clk_out` is constantly 1. With `CLK_DIV_PERIOD_CNT_EN`, `periods` wraps 0xFFFF → 0 after 65536 ticks.
- Async `reset` asserted mid-high phase at N = 5 → `clk_out`, `tick` and `div_busy` are 0 immediately without waiting for a clock edge. The pending divisor is discarded and N returns to 5.
